// File: rtl/des_key_pkg.sv
// Shared tables and types for the DES key scheduler: PC-1/PC-2 permutations,
// the per-round shift amounts, the controller state type and the bit-selection helpers.
package des_key_pkg;

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [3:0] LAST_ROUND = 4'd15;

   // Entries are DES bit numbers (1 = MSB) of the source vector.
   localparam int PC1_TAB [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TAB [0:47] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   localparam logic [1:0] SHIFT_TAB [0:15] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   function automatic logic [1:56] pc1(input logic [1:64] k);
      logic [1:56] r;
      r = '0;
      for (int i = 0; i < 56; i++) r[i+1] = k[PC1_TAB[i]];
      return r;
   endfunction

   function automatic logic [1:48] pc2(input logic [1:56] cd);
      logic [1:48] r;
      r = '0;
      for (int i = 0; i < 48; i++) r[i+1] = cd[PC2_TAB[i]];
      return r;
   endfunction

   // Decrypt walks the encrypt schedule backwards: round r undoes encrypt shift 16-r,
   // and round 0 needs none because the full 28-bit cycle is the identity.
   function automatic logic [1:0] shift_amt(input logic dec, input logic [3:0] round);
      if (!dec) return SHIFT_TAB[round];
      if (round == 4'd0) return 2'd0;
      return SHIFT_TAB[4'(LAST_ROUND - round + 4'd1)];
   endfunction

endpackage

// File: rtl/des_key_rot.sv
// Combinational C/D rotator: rotates each 28-bit half independently,
// left (dir=0) or right (dir=1) by 0, 1 or 2 positions.
module des_key_rot (
   input  logic [1:56] cd_i,
   input  logic        dir,
   input  logic [1:0]  amt,
   output logic [1:56] cd_o
);

   logic [1:28] c, d;

   assign c = cd_i[1:28];
   assign d = cd_i[29:56];

   always_comb begin
      cd_o = cd_i;
      case ({dir, amt})
         3'b001:  cd_o = {c[2:28], c[1],      d[2:28], d[1]};
         3'b010:  cd_o = {c[3:28], c[1:2],    d[3:28], d[1:2]};
         3'b101:  cd_o = {c[28],   c[1:27],   d[28],   d[1:27]};
         3'b110:  cd_o = {c[27:28], c[1:26],  d[27:28], d[1:26]};
         default: cd_o = cd_i;
      endcase
   end

endmodule

// File: rtl/des_key_sched.sv
// Sequential DES key scheduler: one key in, sixteen PC-2 subkeys out over valid/ready.
// Optional odd-parity key check enabled by defining DES_KEY_PARITY_CHK_EN.
module des_key_sched
   import des_key_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_valid,
   output logic        key_ready,
   input  logic [1:64] key,
   input  logic        des_mode,
   output logic        rk_valid,
   input  logic        rk_ready,
   output logic [1:48] rk,
   output logic [3:0]  rk_round,
   output logic        rk_last,
   output logic        busy,
   output logic        parity_err
);

   state_t      state_q, state_d;
   logic [1:56] cd_q, cd_d;
   logic [3:0]  round_q, round_d;
   logic        mode_q, mode_d;

   logic [1:56] rot_in, rot_out;
   logic        rot_dir;
   logic [1:0]  rot_amt;
   logic        key_acc, key_bad;

   assign key_acc = key_valid && (state_q == IDLE);

`ifdef DES_KEY_PARITY_CHK_EN
   logic parity_err_q, parity_err_d;

   always_comb begin
      key_bad = 1'b0;
      for (int b = 0; b < 8; b++) begin
         if (!(^key[8*b+1 +: 8])) key_bad = 1'b1;
      end
      parity_err_d = key_acc && key_bad;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) parity_err_q <= 1'b0;
      else        parity_err_q <= parity_err_d;
   end

   assign parity_err = parity_err_q;
`else
   assign key_bad    = 1'b0;
   assign parity_err = 1'b0;
`endif

   // The single rotator serves the load path in IDLE and the advance path in RUN.
   always_comb begin
      rot_in  = cd_q;
      rot_dir = mode_q;
      rot_amt = shift_amt(mode_q, round_q + 4'd1);
      if (state_q == IDLE) begin
         rot_in  = pc1(key);
         rot_dir = des_mode;
         rot_amt = shift_amt(des_mode, 4'd0);
      end
   end

   des_key_rot u_rot (
      .cd_i (rot_in),
      .dir  (rot_dir),
      .amt  (rot_amt),
      .cd_o (rot_out)
   );

   always_comb begin
      state_d = state_q;
      cd_d    = cd_q;
      round_d = round_q;
      mode_d  = mode_q;
      case (state_q)
         IDLE: begin
            if (key_acc && !key_bad) begin
               mode_d  = des_mode;
               cd_d    = rot_out;
               round_d = 4'd0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (rk_ready) begin
               if (round_q == LAST_ROUND) begin
                  state_d = IDLE;
               end else begin
                  round_d = round_q + 4'd1;
                  cd_d    = rot_out;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cd_q    <= '0;
         round_q <= 4'd0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cd_q    <= cd_d;
         round_q <= round_d;
         mode_q  <= mode_d;
      end
   end

   assign key_ready = (state_q == IDLE);
   assign rk_valid  = (state_q == RUN);
   assign busy      = (state_q == RUN);
   assign rk        = pc2(cd_q);
   assign rk_round  = round_q;
   assign rk_last   = rk_valid && (round_q == LAST_ROUND);

endmodule

// File: doc/des_key_sched.md
# des_key_sched

Sequential DES key scheduler. Accepts one 64-bit DES key with an encrypt/decrypt mode and emits the 16 round subkeys (48-bit, PC-2 output) in round order over a valid/ready stream. It sits directly upstream of the DES round datapath. It replaces per-round external key rotation with an internal C/D register and round counter.

## Interface
- Parameters: none. All widths are fixed by DES.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_valid` in 1: input key offered.
- `key_ready` out 1: high only in IDLE.
- `key` in [1:64]: DES key in DES bit numbering, bit 1 is the MSB. Bits 8, 16, …, 64 are parity bits.
- `des_mode` in 1: 0 selects encrypt, 1 selects decrypt. Sampled only on key accept.
- `rk_valid` out 1: round key valid.
- `rk_ready` in 1: downstream accepts the round key.
- `rk` out [1:48]: round subkey.
- `rk_round` out 4: index of the round currently presented, 0..15.
- `rk_last` out 1: high while `rk_round`==15 and `rk_valid`.
- `busy` out 1: high in RUN.
- `parity_err` out 1: one-cycle pulse on a rejected key. Functional only with the macro defined.

## Operation
- State IDLE:
  - `key_ready`=1.
  - On `key_valid`&&`key_ready`: latch `des_mode` and load `cd_q` = rot(PC1(`key`), mode, round 0). Set round=0 and go to RUN.
- State RUN:
  - `rk_valid`=1.
  - `rk` = PC2(`cd_q`), combinational from the register.
  - On `rk_valid`&&`rk_ready`:
    - If round==15, go to IDLE.
    - Otherwise, round+=1 and `cd_q` = rot(`cd_q`, mode, round+1).
- Rotation rules: each rotation acts on C=[1:28] and D=[29:56] independently, as circular rotates within each half.
- Encrypt shift table:
  - Left-rotate by 1 in rounds 0, 1, 8, 15.
  - Left-rotate by 2 in all other rounds.
- Decrypt shift table:
  - Round 0: no rotation, since the cumulative rotation is 28, which is the identity.
  - Right-rotate by 1 in rounds 1, 8, 15.
  - Right-rotate by 2 in rounds 2–7 and 9–14.
- Boundary conditions:
  - `key_valid` during RUN is ignored and the key is not consumed.
  - `des_mode` changes during RUN are ignored.
  - `rk_ready` low holds `rk`, `rk_round` and `cd_q` stable with no bounded wait.
  - Reset asserted mid-run aborts the schedule immediately. No partial resume.

## Timing
- Reset values:
  - State IDLE, `cd_q`=0, round=0, mode=0.
  - Outputs: `key_ready`=1, `rk_valid`=0, `rk`=0, `rk_round`=0, `rk_last`=0, `busy`=0, `parity_err`=0.
- Key accepted at edge N: `rk_valid`=1 with round 0 in cycle N+1.
- With `rk_ready` held high, one key per cycle: round 15 is presented at N+16, and IDLE is reached at N+17.
- One-cycle bubble between back-to-back keys, because `key_ready` is high only in IDLE. Each key occupies 17 cycles.
- `rk` has no combinational path from any input. It depends on registers only.

## Configuration
- Macro: `DES_KEY_PARITY_CHK_EN`.
- Defined:
  - On accept, every key byte is checked for odd parity.
  - On any failure, the key is consumed but the block stays in IDLE, with no `rk_valid`.
  - `parity_err` pulses high for exactly one cycle, in cycle N+1.
- Undefined:
  - Parity bits are ignored.
  - `parity_err` is tied to 0.

## Structure
- Package `des_key_pkg` holds:
  - PC-1 table (56 entries) and PC-2 table (48 entries).
  - 16-entry shift-amount table.
  - State enum {IDLE, RUN}.
  - Constant LAST_ROUND=15.
- Sub-module `des_key_rot`: combinational. Inputs are 56 bits, direction and amount (1/2); output is the rotated C/D pair. It is used for both the load path and the advance path.

## Test plan
- Encrypt, key 0x133457799BBCDFF1, `rk_ready`=1:
  - Round 0 `rk`=0x1B02EFFC7072.
  - Round 15 `rk`=0xCB3D8B0E17F5.
  - `rk_last` high only in round 15.
  - Back in IDLE at N+17.
- Decrypt, same key:
  - Round 0 `rk`=0xCB3D8B0E17F5.
  - Round 15 `rk`=0x1B02EFFC7072.
  - All 16 keys equal the encrypt sequence in reverse order.
- Backpressure: drop `rk_ready` for 5 cycles while round 3 is presented.
  - `rk` and `rk_round`=3 stay stable.
  - The sequence resumes with round 4 and no key is lost.
- `key_valid` asserted with a different key during RUN: ignored, and the current sequence completes unchanged.
- Assert `rst_n` low during round 7:
  - `rk_valid`=0 and `rk`=0 immediately.
  - After release, `key_ready`=1 and a new key runs from round 0.
- With `DES_KEY_PARITY_CHK_EN`, key 0x123457799BBCDFF1 (byte 0x12 has even parity):
  - One-cycle `parity_err` pulse.
  - No `rk_valid`.
  - `key_ready` remains 1.
